// File: rtl/segment_pkg.sv
// Shared types and constants for the pipeline segment register.
package segment_pkg;

  typedef enum logic [1:0] {
    SEG_EMPTY = 2'd0,
    SEG_FULL  = 2'd1,
    SEG_SKID  = 2'd2
  } seg_state_t;

  localparam int CNT_W = 16;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_FLAGWR   = 5;
  localparam int CTRL_ALUOP_LO = 6;
  localparam int CTRL_ALUOP_W  = 2;
  localparam int CTRL_IMMSRC   = 8;
  localparam int CTRL_REGSRC   = 10;

  function automatic logic [1:0] seg_fill(
    input seg_state_t s
  );
    unique case (s)
      SEG_FULL: return 2'd1;
      SEG_SKID: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [1:0]       b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/segment_entry_reg.sv
// One pipeline entry: control bundle, destination and data lanes.
// Clear wins over load so emptied slots always read as bubbles.
module segment_entry_reg
  import segment_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 3,
  parameter int CTRL_W   = 12,
  parameter int ADDR_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       clear,
  input  logic [CTRL_W-1:0]          d_ctrl,
  input  logic [ADDR_W-1:0]          d_wa3,
  input  logic [NUM_DATA*DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0]          q_ctrl,
  output logic [ADDR_W-1:0]          q_wa3,
  output logic [NUM_DATA*DATA_W-1:0] q_data
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q_ctrl <= '0;
      q_wa3  <= '0;
      q_data <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
      q_wa3  <= d_wa3;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/segment_pipe_reg.sv
// Valid/ready pipeline segment with 2-entry skid and flush-to-bubble.
// Define SEGMENT_PERF_CNT_EN to build the stall/flush counters.
module segment_pipe_reg
  import segment_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 3,
  parameter int CTRL_W   = 12,
  parameter int ADDR_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [ADDR_W-1:0]          in_wa3,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [ADDR_W-1:0]          out_wa3,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int DW = NUM_DATA * DATA_W;

  seg_state_t state, nxt;

  logic accept;
  logic take;
  logic main_ld;
  logic main_clr;
  logic main_from_skid;
  logic skid_ld;
  logic skid_clr;

  logic [CTRL_W-1:0] skid_ctrl;
  logic [ADDR_W-1:0] skid_wa3;
  logic [DW-1:0]     skid_data;

  logic [CTRL_W-1:0] main_d_ctrl;
  logic [ADDR_W-1:0] main_d_wa3;
  logic [DW-1:0]     main_d_data;

  assign in_ready  = (state != SEG_SKID);
  assign out_valid = (state != SEG_EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign take      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= SEG_EMPTY;
    else     state <= nxt;
  end

  always_comb begin
    nxt            = state;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      nxt      = SEG_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state)
        SEG_EMPTY: begin
          if (accept) begin
            nxt     = SEG_FULL;
            main_ld = 1'b1;
          end
        end
        SEG_FULL: begin
          if (accept && take) begin
            main_ld = 1'b1;
          end else if (accept) begin
            nxt     = SEG_SKID;
            skid_ld = 1'b1;
          end else if (take) begin
            nxt      = SEG_EMPTY;
            main_clr = 1'b1;
          end
        end
        SEG_SKID: begin
          if (take) begin
            nxt            = SEG_FULL;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          nxt      = SEG_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_wa3  = main_from_skid ? skid_wa3  : in_wa3;
  assign main_d_data = main_from_skid ? skid_data : in_data;

  segment_entry_reg #(
    .DATA_W   (DATA_W),
    .NUM_DATA (NUM_DATA),
    .CTRL_W   (CTRL_W),
    .ADDR_W   (ADDR_W)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_ld),
    .clear  (main_clr),
    .d_ctrl (main_d_ctrl),
    .d_wa3  (main_d_wa3),
    .d_data (main_d_data),
    .q_ctrl (out_ctrl),
    .q_wa3  (out_wa3),
    .q_data (out_data)
  );

  segment_entry_reg #(
    .DATA_W   (DATA_W),
    .NUM_DATA (NUM_DATA),
    .CTRL_W   (CTRL_W),
    .ADDR_W   (ADDR_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_ld),
    .clear  (skid_clr),
    .d_ctrl (in_ctrl),
    .d_wa3  (in_wa3),
    .d_data (in_data),
    .q_ctrl (skid_ctrl),
    .q_wa3  (skid_wa3),
    .q_data (skid_data)
  );

`ifdef SEGMENT_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && !flush)
        stall_q <= sat_add(stall_q, 2'd1);
      if (flush)
        flush_q <= sat_add(flush_q, seg_fill(state));
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_segment_pipe_reg.sv
// Directed-vector bench for segment_pipe_reg.
module tb_segment_pipe_reg;

  localparam int DATA_W   = 32;
  localparam int NUM_DATA = 3;
  localparam int CTRL_W   = 12;
  localparam int ADDR_W   = 4;
  localparam int DW       = NUM_DATA * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [ADDR_W-1:0] in_wa3;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [ADDR_W-1:0] out_wa3;
  logic [DW-1:0]     out_data;
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  segment_pipe_reg #(
    .DATA_W   (DATA_W),
    .NUM_DATA (NUM_DATA),
    .CTRL_W   (CTRL_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_wa3    (in_wa3),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_wa3   (out_wa3),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  function automatic logic [DW-1:0] mk_data(input logic [7:0] v);
    return {24'h0, v ^ 8'hA5, 24'h0, v ^ 8'h5A, 24'h0, v};
  endfunction

  function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [7:0] v);
    return {4'hC, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] x);
    in_valid = v;
    in_ctrl  = v ? mk_ctrl(x) : '0;
    in_wa3   = v ? x[3:0] : '0;
    in_data  = v ? mk_data(x) : '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 8'h00);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    n_tests++;
    if ({out_ctrl, out_wa3, out_data} !== '0) begin
      n_fail++; $display("FAIL reset_payload got %h want 0", out_data);
    end
    n_tests++;
    if ({stall_cnt, flush_cnt} !== 32'h0) begin
      n_fail++; $display("FAIL reset_cnt got %h want 0", {stall_cnt, flush_cnt});
    end
  endtask

  task automatic test_stream();
    logic [7:0] v [3];
    v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, v[i]);
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== mk_data(v[i])
          || out_ctrl !== mk_ctrl(v[i]) || out_wa3 !== v[i][3:0]) begin
        n_fail++;
        $display("FAIL stream_%0d got v=%b d=%h want d=%h",
                 i, out_valid, out_data, mk_data(v[i]));
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_ready_%0d got %b want 1", i, in_ready);
      end
    end
    drive(1'b0, 8'h00);
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL stream_bubble got v=%b c=%h want v=0 c=0", out_valid, out_ctrl);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 8'hA1);
    tick();
    drive(1'b1, 8'hB2);
    tick();
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== mk_data(8'hA1)) begin
      n_fail++;
      $display("FAIL bp_skid got r=%b d=%h want r=0 d=%h",
               in_ready, out_data, mk_data(8'hA1));
    end
    drive(1'b0, 8'h00);
    tick();
    n_tests++;
    if (out_data !== mk_data(8'hA1) || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold got %h want %h", out_data, mk_data(8'hA1));
    end
    n_tests++;
`ifdef SEGMENT_PERF_CNT_EN
    if (stall_cnt !== 16'd2) begin
      n_fail++; $display("FAIL bp_stall_cnt got %0d want 2", stall_cnt);
    end
`else
    if (stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL bp_stall_cnt got %0d want 0", stall_cnt);
    end
`endif
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== mk_data(8'hB2)
        || out_wa3 !== 4'h2 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain_b got d=%h r=%b want d=%h r=1",
               out_data, in_ready, mk_data(8'hB2));
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      n_fail++; $display("FAIL bp_empty got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush_skid();
    do_reset();
    drive(1'b1, 8'h41);
    tick();
    drive(1'b1, 8'h42);
    tick();
    flush = 1'b1;
    drive(1'b1, 8'hC3);
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00);
    n_tests++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state got v=%b c=%h r=%b want 0 0 1",
               out_valid, out_ctrl, in_ready);
    end
    n_tests++;
`ifdef SEGMENT_PERF_CNT_EN
    if (flush_cnt !== 16'd2) begin
      n_fail++; $display("FAIL flush_cnt got %0d want 2", flush_cnt);
    end
`else
    if (flush_cnt !== 16'd0) begin
      n_fail++; $display("FAIL flush_cnt got %0d want 0", flush_cnt);
    end
`endif
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_fail++; $display("FAIL flush_drop got v=%b d=%h want 0", out_valid, out_data);
    end
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 8'h55);
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_empty got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 8'h70);
    tick();
    drive(1'b1, 8'hD4);
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== mk_data(8'hD4)
        || out_ctrl !== mk_ctrl(8'hD4) || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_d got d=%h r=%b want d=%h r=1",
               out_data, in_ready, mk_data(8'hD4));
    end
    drive(1'b0, 8'h00);
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 8'h91);
    tick();
    drive(1'b1, 8'h92);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 8'h93);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h00);
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1
        || {out_ctrl, out_wa3, out_data} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid got v=%b r=%b d=%h want 0 1 0",
               out_valid, in_ready, out_data);
    end
    n_tests++;
    if ({stall_cnt, flush_cnt} !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_cnt got %h want 0", {stall_cnt, flush_cnt});
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 8'hEE);
    tick();
    drive(1'b0, 8'h00);
    repeat (70000) @(posedge clk);
    #1;
    n_tests++;
`ifdef SEGMENT_PERF_CNT_EN
    if (stall_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL stall_sat got %h want ffff", stall_cnt);
    end
`else
    if (stall_cnt !== 16'h0) begin
      n_fail++; $display("FAIL stall_sat got %h want 0", stall_cnt);
    end
`endif
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== mk_data(8'hEE)) begin
      n_fail++; $display("FAIL stall_hold got %h want %h", out_data, mk_data(8'hEE));
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 8'h00);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_skid();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
